// File: rtl/axil_regfile_if.sv
// Five-channel AXI-lite style bus shared by the register-file slave
// and whichever master drives it.
interface axil_regfile_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    localparam int STRB_W = DATA_W / 8;

    logic [ADDR_W-1:0] write_address;
    logic              AW_VALID;
    logic              AW_READY;
    logic [DATA_W-1:0] write_data;
    logic [STRB_W-1:0] W_STRB;
    logic              W_VALID;
    logic              W_READY;
    logic              B_VALID;
    logic              B_READY;
    logic [1:0]        BRESPONSE;
    logic [ADDR_W-1:0] read_address;
    logic              AR_VALID;
    logic              AR_READY;
    logic [DATA_W-1:0] data_read;
    logic [1:0]        RRESPONSE;
    logic              R_VALID;
    logic              R_READY;

    modport master (
        output write_address, AW_VALID, write_data, W_STRB, W_VALID,
        output B_READY, read_address, AR_VALID, R_READY,
        input  AW_READY, W_READY, B_VALID, BRESPONSE,
        input  AR_READY, data_read, RRESPONSE, R_VALID
    );

    modport slave (
        input  write_address, AW_VALID, write_data, W_STRB, W_VALID,
        input  B_READY, read_address, AR_VALID, R_READY,
        output AW_READY, W_READY, B_VALID, BRESPONSE,
        output AR_READY, data_read, RRESPONSE, R_VALID
    );
endinterface

// File: rtl/axil_regfile_slave.sv
// AXI-lite style register-file slave: independent AW/W capture, byte
// strobes, decode errors, and fully concurrent read and write paths.
module axil_regfile_slave #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 12
) (
    input logic          clk,
    input logic          rst,
    axil_regfile_if.slave bus
);
    localparam int STRB_W = DATA_W / 8;
    localparam logic [ADDR_W:0] DEPTH_L = DEPTH[ADDR_W:0];
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef enum logic [1:0] {W_COLLECT, W_COMMIT, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_DATA} rstate_t;

    logic [DATA_W-1:0] regs [DEPTH];

    wstate_t           wstate;
    logic              aw_held;
    logic              w_held;
    logic [ADDR_W-1:0] aw_addr;
    logic [DATA_W-1:0] wdata_q;
    logic [STRB_W-1:0] wstrb_q;
    logic              b_valid;
    logic [1:0]        bresp;

    rstate_t           rstate;
    logic              r_valid;
    logic [1:0]        rresp;
    logic [DATA_W-1:0] rdata;

    logic aw_ready;
    logic w_ready;
    logic ar_ready;
    logic aw_hs;
    logic w_hs;
    logic ar_hs;
    logic aw_in;
    logic ar_in;

    // Readiness is held low while rst is asserted, then follows state.
    assign aw_ready = !rst && !aw_held && !b_valid;
    assign w_ready  = !rst && !w_held && !b_valid;
    assign ar_ready = !rst && (rstate == R_IDLE);

    assign aw_hs = bus.AW_VALID && aw_ready;
    assign w_hs  = bus.W_VALID && w_ready;
    assign ar_hs = bus.AR_VALID && ar_ready;

    assign aw_in = {1'b0, aw_addr} < DEPTH_L;
    assign ar_in = {1'b0, bus.read_address} < DEPTH_L;

    assign bus.AW_READY  = aw_ready;
    assign bus.W_READY   = w_ready;
    assign bus.B_VALID   = b_valid;
    assign bus.BRESPONSE = bresp;
    assign bus.AR_READY  = ar_ready;
    assign bus.R_VALID   = r_valid;
    assign bus.RRESPONSE = rresp;
    assign bus.data_read = rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            wstate  <= W_COLLECT;
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            aw_addr <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            b_valid <= 1'b0;
            bresp   <= OKAY;
            for (int k = 0; k < DEPTH; k++)
                regs[k] <= '0;
        end else begin
            unique case (wstate)
                W_COLLECT: begin
                    if (aw_hs) begin
                        aw_held <= 1'b1;
                        aw_addr <= bus.write_address;
                    end
                    if (w_hs) begin
                        w_held  <= 1'b1;
                        wdata_q <= bus.write_data;
                        wstrb_q <= bus.W_STRB;
                    end
                    if (aw_held && w_held)
                        wstate <= W_COMMIT;
                end
                W_COMMIT: begin
                    if (aw_in) begin
                        for (int i = 0; i < STRB_W; i++)
                            if (wstrb_q[i])
                                regs[aw_addr][8*i +: 8] <= wdata_q[8*i +: 8];
                    end
                    bresp   <= aw_in ? OKAY : SLVERR;
                    b_valid <= 1'b1;
                    aw_held <= 1'b0;
                    w_held  <= 1'b0;
                    wstate  <= W_RESP;
                end
                W_RESP: begin
                    if (bus.B_READY) begin
                        b_valid <= 1'b0;
                        wstate  <= W_COLLECT;
                    end
                end
                default: wstate <= W_COLLECT;
            endcase
        end
    end

    // Reads sample the array before any same-edge commit lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            rstate  <= R_IDLE;
            r_valid <= 1'b0;
            rresp   <= OKAY;
            rdata   <= '0;
        end else begin
            unique case (rstate)
                R_IDLE: begin
                    if (ar_hs) begin
                        rdata   <= ar_in ? regs[bus.read_address] : '0;
                        rresp   <= ar_in ? OKAY : SLVERR;
                        r_valid <= 1'b1;
                        rstate  <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (bus.R_READY) begin
                        r_valid <= 1'b0;
                        rstate  <= R_IDLE;
                    end
                end
                default: rstate <= R_IDLE;
            endcase
        end
    end
endmodule
